uart_tx_sched: RTL and testbench

Round-robin scheduler that shares a single UART transmitter, and its 8-bit transmit holding register, between up to N_REQ requesters. Per transaction it picks one pending requester, latches that requester's byte into the holding register with a one-cycle save strobe, and issues a transmit start. It then waits for the transmitter to report completion before serving the next requester. It sits between the application-side byte producers and the UART TX bit engine.

---
 rtl/uart_tx_sched_pkg.sv | 13 +
 rtl/uart_tx_sched_rr_arbiter.sv | 35 +++
 rtl/uart_tx_sched.sv | 140 ++++++++++++++
 tb/tb_uart_tx_sched.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the round-robin UART transmit scheduler.
package uart_tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  localparam int DEFAULT_DW      = 8;
  localparam int DEFAULT_TIMEOUT = 65535;

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module rr_arbiter
  import uart_tx_sched_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [$clog2(N_REQ)-1:0] gnt_idx_o,
  output logic                     any_o
);

  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0] idx;

  // Scan from the farthest offset down so the nearest set bit wins last.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    idx       = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = IW'((int'(ptr_i) + i) % N_REQ);
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between N_REQ byte producers in round-robin order,
// with a saturating timeout that abandons a transfer the TX engine never completes.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DW      = DEFAULT_DW,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DW-1:0]      data_i,
  output logic [N_REQ-1:0]         ack,
  output logic [DW-1:0]            data_o,
  output logic                     save_o,
  output logic                     tx_start,
  input  logic                     tx_done,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     err_o
);

  localparam int            IW   = $clog2(N_REQ);
  localparam int            CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic [DW-1:0]    data_q, data_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             save_q, save_d;
  logic             start_q, start_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    gnt_idx;
  logic             any;
  logic             timeout_hit;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i     (req),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (any)
  );

  // A completion arriving on the last allowed cycle still counts as success.
  assign timeout_hit = (state_q == WAIT_DONE) && !tx_done && (cnt_q == TMAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (any) state_d = START;
      START:     state_d = WAIT_DONE;
      WAIT_DONE: if (tx_done || timeout_hit) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_d    = '0;
    save_d   = 1'b0;
    start_d  = 1'b0;
    err_d    = 1'b0;
    data_d   = data_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    busy_d   = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (any) begin
          ack_d   = gnt;
          save_d  = 1'b1;
          data_d  = data_i[gnt_idx*DW +: DW];
          grant_d = gnt_idx;
        end
      end
      START: begin
        start_d = 1'b1;
        cnt_d   = '0;
      end
      WAIT_DONE: begin
        if (tx_done || timeout_hit) begin
          rr_ptr_d = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
          err_d    = timeout_hit;
        end else if (cnt_q != TMAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      grant_q  <= '0;
      data_q   <= '0;
      ack_q    <= '0;
      save_q   <= 1'b0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      ack_q    <= ack_d;
      save_q   <= save_d;
      start_q  <= start_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ack      = ack_q;
  assign data_o   = data_q;
  assign save_o   = save_q;
  assign tx_start = start_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed and randomized checks of uart_tx_sched against a round-robin reference model.
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] data_i;
  logic [3:0]  ack;
  logic [7:0]  data_o;
  logic        save_o;
  logic        tx_start;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        busy;
  logic        err_o;

  int checks   = 0;
  int failures = 0;
  int mptr     = 0;

  uart_tx_sched #(.N_REQ(4), .DW(8), .TIMEOUT(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .data_i   (data_i),
    .ack      (ack),
    .data_o   (data_o),
    .save_o   (save_o),
    .tx_start (tx_start),
    .tx_done  (tx_done),
    .grant_id (grant_id),
    .busy     (busy),
    .err_o    (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference rule: first requester at or after the pointer, wrapping around four slots.
  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // lat = cycles from tx_start to tx_done; lat = 0 means tx_done never comes.
  task automatic run_txn(input logic [3:0] r, input logic [31:0] d, input int lat, input bit hold);
    int w;
    w = pick(r, mptr);
    req = r;
    data_i = d;
    @(negedge clk);
    tx_done = 1'b0;
    chk("ack", ack, 32'(1) << w);
    chk("save_o", save_o, 1);
    chk("data_o", data_o, d[w*8 +: 8]);
    chk("grant_id", grant_id, w);
    chk("busy_rise", busy, 1);
    chk("early_start", tx_start, 0);
    chk("err_idle", err_o, 0);
    if (!hold) req = 4'b0000;
    @(negedge clk);
    chk("tx_start", tx_start, 1);
    chk("ack_pulse", ack, 0);
    chk("save_pulse", save_o, 0);
    if (lat > 0) begin
      for (int k = 1; k <= lat; k++) begin
        @(negedge clk);
        chk("busy_wait", busy, 1);
        chk("err_wait", err_o, 0);
      end
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      chk("busy_done", busy, 0);
      chk("err_done", err_o, 0);
    end else begin
      for (int k = 1; k <= 15; k++) begin
        @(negedge clk);
        chk("err_early", err_o, 0);
        chk("busy_to", busy, 1);
      end
      @(negedge clk);
      chk("err_timeout", err_o, 1);
      chk("busy_timeout", busy, 0);
    end
    mptr = (w + 1) % 4;
    $display("txn req=%b winner=%0d byte=%02h lat=%0d hold=%0d", r, w, d[w*8 +: 8], lat, hold);
  endtask

  initial begin
    logic [3:0]  r;
    logic [31:0] d;
    int          lat;
    rst_n = 1'b0;
    req = 4'b0000;
    data_i = 32'h0;
    tx_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_data", data_o, 0);
    chk("rst_ack", ack, 0);
    chk("rst_grant", grant_id, 0);
    rst_n = 1'b1;

    // Idle: nothing requested, nothing happens.
    data_i = 32'h1234_5678;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("idle_ack", ack, 0);
      chk("idle_save", save_o, 0);
      chk("idle_start", tx_start, 0);
      chk("idle_busy", busy, 0);
      chk("idle_data", data_o, 0);
    end

    run_txn(4'b0100, 32'h00A5_0000, 10, 1'b0);
    run_txn(4'b1001, $urandom, 4, 1'b0);
    run_txn(4'b0001, $urandom, 3, 1'b0);
    run_txn(4'b0011, $urandom, 6, 1'b0);
    run_txn(4'b0001, $urandom, 2, 1'b0);

    // Timeout, then a late tx_done in IDLE must not disturb the next grant.
    run_txn(4'b0110, $urandom, 0, 1'b0);
    tx_done = 1'b1;
    run_txn(4'b0100, $urandom, 5, 1'b0);

    // Reset in the middle of WAIT_DONE.
    req = 4'b1000;
    data_i = $urandom;
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", data_o, 0);
    chk("mid_rst_grant", grant_id, 0);
    chk("mid_rst_start", tx_start, 0);
    chk("mid_rst_ack", ack, 0);
    rst_n = 1'b1;
    mptr = 0;
    run_txn(4'b0110, $urandom, 4, 1'b0);
    chk("post_rst_winner", grant_id, 1);

    // Fairness from a fresh pointer with every requester held.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mptr = 0;
    for (int n = 0; n < 6; n++) begin
      run_txn(4'b1111, $urandom, 5, 1'b1);
      chk("fair_order", grant_id, n % 4);
    end
    req = 4'b0000;

    for (int n = 0; n < 24; n++) begin
      r   = 4'($urandom_range(1, 15));
      d   = $urandom;
      lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15));
      run_txn(r, d, lat, 1'($urandom_range(0, 1)));
    end
    req = 4'b0000;
    @(negedge clk);
    chk("final_ack", ack, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
